// File: rtl/mvm_pkg.sv
// Shared MVM definitions: command op encodings, tuser field layout, tx FSM states.
// Used by mvm_cmd_tx and the rtl_mvm side that decodes the same tuser fields.
package mvm_pkg;

    typedef enum logic [1:0] {
        OP_INST  = 2'b00,
        OP_RVEC  = 2'b01,
        OP_IVEC  = 2'b10,
        OP_RF_WR = 2'b11
    } mvm_op_e;

    // tuser layout: [8:0] address, [10:9] op, [11] RF select, upper bits zero
    localparam int TU_ADDR_LSB  = 0;
    localparam int TU_ADDR_W    = 9;
    localparam int TU_OP_LSB    = 9;
    localparam int TU_RFSEL_BIT = 11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } tx_state_e;

endpackage

// File: rtl/axis_out_reg.sv
// One-entry valid/ready pipeline register; one cycle latency, full throughput.
// Accepts a new entry when empty or when the held entry drains in the same cycle.
module axis_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_valid_i && in_ready_o) begin
            valid_q <= 1'b1;
            data_q  <= in_data_i;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/mvm_cmd_tx.sv
// Turns (command, data beats) into single-flit AXIS packets tagged with RF/vector address in tuser.
// Beat appears one cycle after its data handshake; dat_ready follows the output register's space.
module mvm_cmd_tx
    import mvm_pkg::*;
#(
    parameter int DATAW   = 512,
    parameter int BYTEW   = 8,
    parameter int IDW     = 32,
    parameter int DESTW   = 12,
    parameter int USERW   = 75,
    parameter int RFADDRW = 9,
    parameter int LENW    = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic               cmd_rf_sel,
    input  logic [RFADDRW-1:0] cmd_addr,
    input  logic [LENW-1:0]    cmd_len,
    input  logic [DESTW-1:0]   cmd_dest,
    input  logic               dat_valid,
    output logic               dat_ready,
    input  logic [DATAW-1:0]   dat_data,
    output logic               axis_tx_tvalid,
    output logic [DATAW-1:0]   axis_tx_tdata,
    output logic [BYTEW-1:0]   axis_tx_tstrb,
    output logic [BYTEW-1:0]   axis_tx_tkeep,
    output logic [IDW-1:0]     axis_tx_tid,
    output logic [DESTW-1:0]   axis_tx_tdest,
    output logic [USERW-1:0]   axis_tx_tuser,
    output logic               axis_tx_tlast,
    input  logic               axis_tx_tready,
    output logic               busy
);

    localparam int PW = DATAW + DESTW + USERW;
    localparam int AW = (RFADDRW < TU_ADDR_W) ? RFADDRW : TU_ADDR_W;

    tx_state_e          state_q;
    logic [LENW-1:0]    remaining_q;
    logic [RFADDRW-1:0] addr_q;
    mvm_op_e            op_q;
    logic               rf_sel_q;
    logic [DESTW-1:0]   dest_q;

    logic               out_in_ready;
    logic               dat_hs;
    logic [USERW-1:0]   tuser_d;
    logic [PW-1:0]      beat_d;
    logic [PW-1:0]      beat_q;

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_BURST);
    assign dat_ready = (state_q == ST_BURST) && out_in_ready;
    assign dat_hs    = dat_valid && dat_ready;

    always_comb begin
        tuser_d                          = '0;
        tuser_d[TU_ADDR_LSB +: AW]       = addr_q[AW-1:0];
        tuser_d[TU_OP_LSB +: 2]          = op_q;
        tuser_d[TU_RFSEL_BIT]            = rf_sel_q;
        beat_d                           = {dat_data, dest_q, tuser_d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            addr_q      <= '0;
            op_q        <= OP_INST;
            rf_sel_q    <= 1'b0;
            dest_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // zero-length commands are consumed here without leaving IDLE
                    if (cmd_valid && cmd_len != '0) begin
                        op_q        <= mvm_op_e'(cmd_op);
                        rf_sel_q    <= cmd_rf_sel;
                        addr_q      <= cmd_addr;
                        dest_q      <= cmd_dest;
                        remaining_q <= cmd_len;
                        state_q     <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (dat_hs) begin
                        addr_q      <= addr_q + RFADDRW'(1);
                        remaining_q <= remaining_q - LENW'(1);
                        if (remaining_q == LENW'(1)) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    axis_out_reg #(
        .W (PW)
    ) u_out_reg (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (dat_hs),
        .in_ready_o  (out_in_ready),
        .in_data_i   (beat_d),
        .out_valid_o (axis_tx_tvalid),
        .out_ready_i (axis_tx_tready),
        .out_data_o  (beat_q)
    );

    assign {axis_tx_tdata, axis_tx_tdest, axis_tx_tuser} = beat_q;
    assign axis_tx_tstrb = '1;
    assign axis_tx_tkeep = '1;
    assign axis_tx_tid   = '0;
    assign axis_tx_tlast = 1'b1;

endmodule

// File: tb/tb_mvm_cmd_tx.sv
// Directed scoreboard bench for mvm_cmd_tx: stimulus pushes expected beats, monitor pops on AXIS handshake.
module tb_mvm_cmd_tx;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'b00;
    logic         cmd_rf_sel = 1'b0;
    logic [8:0]   cmd_addr = '0;
    logic [9:0]   cmd_len = '0;
    logic [11:0]  cmd_dest = '0;
    logic         dat_valid = 1'b0;
    logic         dat_ready;
    logic [511:0] dat_data = '0;
    logic         tvalid;
    logic [511:0] tdata;
    logic [7:0]   tstrb;
    logic [7:0]   tkeep;
    logic [31:0]  tid;
    logic [11:0]  tdest;
    logic [74:0]  tuser;
    logic         tlast;
    logic         tready = 1'b1;
    logic         busy;

    typedef struct {
        logic [511:0] data;
        logic [11:0]  tu;
        logic [11:0]  dest;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic         stall_v = 1'b0;
    logic [598:0] snap;

    always #5 clk = ~clk;

    mvm_cmd_tx dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_rf_sel     (cmd_rf_sel),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .cmd_dest       (cmd_dest),
        .dat_valid      (dat_valid),
        .dat_ready      (dat_ready),
        .dat_data       (dat_data),
        .axis_tx_tvalid (tvalid),
        .axis_tx_tdata  (tdata),
        .axis_tx_tstrb  (tstrb),
        .axis_tx_tkeep  (tkeep),
        .axis_tx_tid    (tid),
        .axis_tx_tdest  (tdest),
        .axis_tx_tuser  (tuser),
        .axis_tx_tlast  (tlast),
        .axis_tx_tready (tready),
        .busy           (busy)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic [511:0] d, input logic [11:0] tu, input logic [11:0] dest);
        exp_t x;
        x.data = d;
        x.tu   = tu;
        x.dest = dest;
        sb.push_back(x);
    endtask

    // called just after a posedge; holds cmd_valid until the handshake edge
    task automatic send_cmd(input logic [1:0] op, input logic rf, input logic [8:0] addr,
                            input logic [9:0] len, input logic [11:0] dest);
        int cyc = 0;
        cmd_op = op; cmd_rf_sel = rf; cmd_addr = addr; cmd_len = len; cmd_dest = dest;
        cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("cmd_handshake", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [511:0] d);
        int cyc = 0;
        dat_valid = 1'b1;
        dat_data  = d;
        @(negedge clk);
        while (!dat_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("dat_handshake", 64'(dat_ready), 64'd1);
        @(posedge clk); #1;
        dat_valid = 1'b0;
    endtask

    // scoreboard monitor and output-stability checker
    always @(negedge clk) begin
        if (rst) begin
            stall_v = 1'b0;
        end else begin
            if (stall_v) begin
                n_tests++;
                if ({tvalid, tdata, tuser, tdest} !== {1'b1, snap}) begin
                    n_fail++;
                    $display("FAIL stall_hold: got tvalid=%0b tuser=%0h tdest=%0h, expected held tuser=%0h tdest=%0h",
                             tvalid, tuser, tdest, snap[86:12], snap[11:0]);
                end
            end
            stall_v = tvalid && !tready;
            snap    = {tdata, tuser, tdest};
            if (tvalid && tready) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat: got tuser=%0h tdest=%0h, expected no beat", tuser, tdest);
                end else begin
                    e = sb.pop_front();
                    if (tdata !== e.data || tuser !== 75'(e.tu) || tdest !== e.dest ||
                        tlast !== 1'b1 || tstrb !== 8'hFF || tkeep !== 8'hFF || tid !== 32'd0) begin
                        n_fail++;
                        $display("FAIL beat: got tuser=%0h tdest=%0h tlast=%0b tstrb=%0h tkeep=%0h tid=%0h tdata=%0h, expected tuser=%0h tdest=%0h tdata=%0h",
                                 tuser, tdest, tlast, tstrb, tkeep, tid, tdata, e.tu, e.dest, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", 64'(tvalid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_fields", 64'(|{tdata, tuser, tdest}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // single RF write beat
        push_exp({64{8'h01}}, 12'hE01, 12'h005);
        send_cmd(2'b11, 1'b1, 9'd1, 10'd1, 12'h005);
        check("busy_after_cmd", 64'(busy), 64'd1);
        send_beat({64{8'h01}});
        check("idle_after_len1", 64'(cmd_ready), 64'd1);

        // input vector, four back-to-back beats
        push_exp({64{8'h10}}, 12'h400, 12'h010);
        push_exp({64{8'h11}}, 12'h401, 12'h010);
        push_exp({64{8'h12}}, 12'h402, 12'h010);
        push_exp({64{8'h13}}, 12'h403, 12'h010);
        send_cmd(2'b10, 1'b0, 9'd0, 10'd4, 12'h010);
        send_beat({64{8'h10}});
        send_beat({64{8'h11}});
        send_beat({64{8'h12}});
        check("busy_before_last", 64'(busy), 64'd1);
        send_beat({64{8'h13}});
        check("busy_after_4th", 64'(busy), 64'd0);

        // reduction vector wrapping 510 -> 511 -> 0
        push_exp({64{8'hA0}}, 12'h3FE, 12'h03C);
        push_exp({64{8'hA1}}, 12'h3FF, 12'h03C);
        push_exp({64{8'hA2}}, 12'h200, 12'h03C);
        send_cmd(2'b01, 1'b0, 9'd510, 10'd3, 12'h03C);
        send_beat({64{8'hA0}});
        send_beat({64{8'hA1}});
        send_beat({64{8'hA2}});

        // backpressure: first beat held for 5 cycles
        push_exp({64{8'h55}}, 12'h607, 12'h7FF);
        push_exp({64{8'hAA}}, 12'h608, 12'h7FF);
        send_cmd(2'b11, 1'b0, 9'd7, 10'd2, 12'h7FF);
        tready = 1'b0;
        send_beat({64{8'h55}});
        dat_valid = 1'b1;
        dat_data  = {64{8'hAA}};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_dat_ready", 64'(dat_ready), 64'd0);
            check("stall_tvalid", 64'(tvalid), 64'd1);
            @(posedge clk); #1;
        end
        tready = 1'b1;
        send_beat({64{8'hAA}});
        @(posedge clk); #1;

        // zero-length command
        send_cmd(2'b00, 1'b0, 9'd3, 10'd0, 12'h001);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("len0_cmd_ready", 64'(cmd_ready), 64'd1);
            check("len0_tvalid", 64'(tvalid), 64'd0);
            @(posedge clk); #1;
        end

        // reset after 2 of 8 beats; second beat stalled then dropped
        push_exp({64{8'hC0}}, 12'h464, 12'h0AB);
        send_cmd(2'b10, 1'b0, 9'd100, 10'd8, 12'h0AB);
        send_beat({64{8'hC0}});
        send_beat({64{8'hC1}});
        tready    = 1'b0;
        rst       = 1'b1;
        dat_valid = 1'b1;
        dat_data  = {64{8'hC2}};
        @(posedge clk); #1;
        check("midrst_tvalid", 64'(tvalid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("midrst_fields", 64'(|{tdata, tuser, tdest}), 64'd0);
        rst    = 1'b0;
        tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_dat_ready", 64'(dat_ready), 64'd0);
            check("post_rst_tvalid", 64'(tvalid), 64'd0);
            @(posedge clk); #1;
        end
        dat_valid = 1'b0;

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
